// File: rtl/wb_regfile.sv
// Writeback-stage register file (R0-R14, R15 = PC+8) with write-first bypass
// to three decode read ports, plus retirement and event counters.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [3:0]        WriteAddrW,
  input  logic              StoreW,
  input  logic              CmpW,
  input  logic              BranchW,
  input  logic              LoadW,
  input  logic              PCSrcW,
  input  logic [3:0]        RA1,
  input  logic [3:0]        RA2,
  input  logic [3:0]        RA3,
  input  logic [DATA_W-1:0] PCPlus8,
  input  logic              CntClear,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3,
  output logic [DATA_W-1:0] ResultW,
  output logic              PCWriteW,
  output logic [CNT_W-1:0]  InstRetCnt,
  output logic [CNT_W-1:0]  LoadCnt,
  output logic [CNT_W-1:0]  StoreCnt,
  output logic [CNT_W-1:0]  TakenCnt
);

  localparam int unsigned NUM_REGS = 15;
  localparam logic [3:0]  PC_ADDR  = 4'd15;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              arr_write;
  logic              retire;

  // Writeback result select and PC-redirect decode.
  always_comb begin
    ResultW   = MemtoRegW ? ReadDataW : ALUOutW;
    PCWriteW  = RegWriteW && (WriteAddrW == PC_ADDR);
    arr_write = RegWriteW && (WriteAddrW != PC_ADDR);
    retire    = RegWriteW | StoreW | CmpW | BranchW | LoadW;
  end

  // Array commit; writes to R15 redirect fetch and never land here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (arr_write) begin
      regs[WriteAddrW] <= ResultW;
    end
  end

  // R15 reads return PC+8; a pending write to the same register is bypassed.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] ra);
    logic [DATA_W-1:0] val;
    if (ra == PC_ADDR) begin
      val = PCPlus8;
    end else if (arr_write && (WriteAddrW == ra)) begin
      val = ResultW;
    end else begin
      val = regs[ra];
    end
    return val;
  endfunction

  always_comb begin
    RD1 = read_port(RA1);
    RD2 = read_port(RA2);
    RD3 = read_port(RA3);
  end

  // Event counters: reset beats clear beats increment; wrap is natural.
  always_ff @(posedge clk) begin
    if (!reset || CntClear) begin
      InstRetCnt <= '0;
      LoadCnt    <= '0;
      StoreCnt   <= '0;
      TakenCnt   <= '0;
    end else if (retire) begin
      InstRetCnt <= InstRetCnt + CNT_W'(1);
      LoadCnt    <= LoadCnt    + CNT_W'(LoadW);
      StoreCnt   <= StoreCnt   + CNT_W'(StoreW);
      TakenCnt   <= TakenCnt   + CNT_W'(PCSrcW);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed checks of wb_regfile against a behavioural model;
// a second narrow-counter instance exercises counter wrap-around.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW, PCPlus8;
  logic [3:0]  WriteAddrW, RA1, RA2, RA3;
  logic        StoreW, CmpW, BranchW, LoadW, PCSrcW, CntClear;
  logic [31:0] RD1, RD2, RD3, ResultW;
  logic        PCWriteW;
  logic [31:0] InstRetCnt, LoadCnt, StoreCnt, TakenCnt;
  logic [31:0] s_rd1, s_rd2, s_rd3, s_result;
  logic        s_pcw;
  logic [3:0]  s_inst, s_load, s_store, s_taken;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] m_regs [15];
  logic [31:0] m_inst, m_load, m_store, m_taken;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteAddrW(WriteAddrW),
    .StoreW(StoreW), .CmpW(CmpW), .BranchW(BranchW), .LoadW(LoadW), .PCSrcW(PCSrcW),
    .RA1(RA1), .RA2(RA2), .RA3(RA3), .PCPlus8(PCPlus8), .CntClear(CntClear),
    .RD1(RD1), .RD2(RD2), .RD3(RD3), .ResultW(ResultW), .PCWriteW(PCWriteW),
    .InstRetCnt(InstRetCnt), .LoadCnt(LoadCnt), .StoreCnt(StoreCnt), .TakenCnt(TakenCnt)
  );

  wb_regfile #(.DATA_W(32), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteAddrW(WriteAddrW),
    .StoreW(StoreW), .CmpW(CmpW), .BranchW(BranchW), .LoadW(LoadW), .PCSrcW(PCSrcW),
    .RA1(RA1), .RA2(RA2), .RA3(RA3), .PCPlus8(PCPlus8), .CntClear(CntClear),
    .RD1(s_rd1), .RD2(s_rd2), .RD3(s_rd3), .ResultW(s_result), .PCWriteW(s_pcw),
    .InstRetCnt(s_inst), .LoadCnt(s_load), .StoreCnt(s_store), .TakenCnt(s_taken)
  );

  function automatic logic [31:0] m_result();
    return MemtoRegW ? ReadDataW : ALUOutW;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] ra);
    if (ra == 4'd15) return PCPlus8;
    if (RegWriteW && WriteAddrW == ra) return m_result();
    return m_regs[ra];
  endfunction

  // Apply the spec's posedge rules to the model, then advance one cycle.
  task automatic tick();
    bit ret;
    ret = RegWriteW | StoreW | CmpW | BranchW | LoadW;
    if (!reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 32'd0;
      m_inst = 0; m_load = 0; m_store = 0; m_taken = 0;
    end else begin
      if (RegWriteW && WriteAddrW != 4'd15) m_regs[WriteAddrW] = m_result();
      if (CntClear) begin
        m_inst = 0; m_load = 0; m_store = 0; m_taken = 0;
      end else if (ret) begin
        m_inst  = m_inst + 1;
        m_load  = m_load + (LoadW ? 1 : 0);
        m_store = m_store + (StoreW ? 1 : 0);
        m_taken = m_taken + (PCSrcW ? 1 : 0);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    RegWriteW = 0; MemtoRegW = 0; StoreW = 0; CmpW = 0; BranchW = 0;
    LoadW = 0; PCSrcW = 0; CntClear = 0; WriteAddrW = 0;
    ReadDataW = 0; ALUOutW = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle(); RA1 = 0; RA2 = 0; RA3 = 0; PCPlus8 = 32'h108;
    tick(); tick();
    reset = 1;
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i); #1;
      checks++;
      if (RD1 !== 32'd0) begin
        errors++; $display("FAIL reset_reg R%0d got=%h exp=0", i, RD1);
      end
    end
    RA1 = 4'd15; #1;
    checks++;
    if (RD1 !== 32'h108) begin errors++; $display("FAIL reset_pc got=%h exp=108", RD1); end
    checks++;
    if ({InstRetCnt, LoadCnt, StoreCnt, TakenCnt} !== 128'd0) begin
      errors++; $display("FAIL reset_cnt got=%h %h %h %h exp=0", InstRetCnt, LoadCnt, StoreCnt, TakenCnt);
    end
  endtask

  task automatic test_bypass();
    idle(); RegWriteW = 1; ALUOutW = 32'hDEADBEEF; ReadDataW = 32'h1111; WriteAddrW = 3; RA2 = 3;
    #1;
    checks++;
    if (RD2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass got=%h exp=deadbeef", RD2); end
    checks++;
    if (ResultW !== 32'hDEADBEEF) begin errors++; $display("FAIL result_alu got=%h exp=deadbeef", ResultW); end
    tick(); idle(); #1;
    checks++;
    if (RD2 !== 32'hDEADBEEF) begin errors++; $display("FAIL array_read got=%h exp=deadbeef", RD2); end
  endtask

  task automatic test_load();
    idle(); CntClear = 1; tick();
    idle(); RegWriteW = 1; MemtoRegW = 1; ReadDataW = 32'h12345678; ALUOutW = 32'h1;
    LoadW = 1; WriteAddrW = 7;
    tick(); idle(); RA1 = 7; #1;
    checks++;
    if (RD1 !== 32'h12345678) begin errors++; $display("FAIL load_data got=%h exp=12345678", RD1); end
    checks++;
    if (LoadCnt !== 32'd1 || InstRetCnt !== 32'd1) begin
      errors++; $display("FAIL load_cnt got=%0d/%0d exp=1/1", LoadCnt, InstRetCnt);
    end
  endtask

  task automatic test_pc_write();
    idle(); CntClear = 1; tick();
    idle(); RegWriteW = 1; WriteAddrW = 15; PCSrcW = 1; BranchW = 1; ALUOutW = 32'h5555;
    RA3 = 15; RA2 = 3; PCPlus8 = 32'h200; #1;
    checks++;
    if (PCWriteW !== 1'b1) begin errors++; $display("FAIL pcwrite got=%b exp=1", PCWriteW); end
    checks++;
    if (RD3 !== 32'h200) begin errors++; $display("FAIL pc_read got=%h exp=200", RD3); end
    checks++;
    if (RD2 !== 32'hDEADBEEF) begin errors++; $display("FAIL no_bypass_r15 got=%h exp=deadbeef", RD2); end
    tick(); idle();
    checks++;
    if (TakenCnt !== 32'd1 || InstRetCnt !== 32'd1) begin
      errors++; $display("FAIL pc_cnt got=%0d/%0d exp=1/1", TakenCnt, InstRetCnt);
    end
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i); #1;
      checks++;
      if (RD1 !== m_regs[i]) begin errors++; $display("FAIL pc_regs R%0d got=%h exp=%h", i, RD1, m_regs[i]); end
    end
  endtask

  task automatic test_counters();
    idle(); CntClear = 1; tick();
    idle(); StoreW = 1; tick();
    idle(); CmpW = 1; tick();
    idle(); tick(); tick();
    BranchW = 1; PCSrcW = 1; tick(); idle();
    checks++;
    if (InstRetCnt !== 32'd3 || StoreCnt !== 32'd1 || TakenCnt !== 32'd1 || LoadCnt !== 32'd0) begin
      errors++; $display("FAIL seq_cnt got=%0d %0d %0d %0d exp=3 1 1 0", InstRetCnt, StoreCnt, TakenCnt, LoadCnt);
    end
    CntClear = 1; StoreW = 1; LoadW = 1; tick(); idle();
    checks++;
    if ({InstRetCnt, LoadCnt, StoreCnt, TakenCnt} !== 128'd0) begin
      errors++; $display("FAIL clear_cnt got=%0d %0d %0d %0d exp=0", InstRetCnt, LoadCnt, StoreCnt, TakenCnt);
    end
    RA1 = 7; #1;
    checks++;
    if (RD1 !== 32'h12345678) begin errors++; $display("FAIL clear_keeps_regs got=%h exp=12345678", RD1); end
  endtask

  task automatic test_reset_write();
    idle(); reset = 0; RegWriteW = 1; WriteAddrW = 5; ALUOutW = 32'hAA; StoreW = 1;
    tick(); idle(); reset = 1; RA1 = 5; #1;
    checks++;
    if (RD1 !== 32'd0) begin errors++; $display("FAIL reset_drop got=%h exp=0", RD1); end
    checks++;
    if (InstRetCnt !== 32'd0) begin errors++; $display("FAIL reset_noret got=%0d exp=0", InstRetCnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 40) != 0);
      RegWriteW  = $urandom_range(0, 1) == 1;
      MemtoRegW  = $urandom_range(0, 1) == 1;
      ReadDataW  = $urandom; ALUOutW = $urandom; PCPlus8 = $urandom;
      WriteAddrW = 4'($urandom_range(0, 15));
      StoreW = $urandom_range(0, 3) == 0; CmpW = $urandom_range(0, 3) == 0;
      BranchW = $urandom_range(0, 3) == 0; LoadW = $urandom_range(0, 3) == 0;
      PCSrcW = $urandom_range(0, 1) == 1;
      CntClear = $urandom_range(0, 20) == 0;
      RA1 = ($urandom_range(0, 2) == 0) ? WriteAddrW : 4'($urandom_range(0, 15));
      RA2 = ($urandom_range(0, 2) == 0) ? RA1 : 4'($urandom_range(0, 15));
      RA3 = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (RD1 !== m_read(RA1) || RD2 !== m_read(RA2) || RD3 !== m_read(RA3)) begin
        errors++;
        $display("FAIL rand_read n=%0d got=%h %h %h exp=%h %h %h", n, RD1, RD2, RD3,
                 m_read(RA1), m_read(RA2), m_read(RA3));
      end
      checks++;
      if (ResultW !== m_result() || PCWriteW !== (RegWriteW && WriteAddrW == 4'd15)) begin
        errors++; $display("FAIL rand_result n=%0d got=%h/%b exp=%h", n, ResultW, PCWriteW, m_result());
      end
      checks++;
      if (s_rd1 !== m_read(RA1)) begin errors++; $display("FAIL rand_small_read n=%0d got=%h exp=%h", n, s_rd1, m_read(RA1)); end
      tick();
      checks++;
      if (InstRetCnt !== m_inst || LoadCnt !== m_load || StoreCnt !== m_store || TakenCnt !== m_taken) begin
        errors++;
        $display("FAIL rand_cnt n=%0d got=%0d %0d %0d %0d exp=%0d %0d %0d %0d", n, InstRetCnt, LoadCnt,
                 StoreCnt, TakenCnt, m_inst, m_load, m_store, m_taken);
      end
      checks++;
      if (s_inst !== m_inst[3:0] || s_load !== m_load[3:0] || s_store !== m_store[3:0] || s_taken !== m_taken[3:0]) begin
        errors++; $display("FAIL rand_small_cnt n=%0d got=%h %h %h %h", n, s_inst, s_load, s_store, s_taken);
      end
    end
    reset = 1; idle();
  endtask

  task automatic test_wrap();
    idle(); CntClear = 1; tick();
    idle(); StoreW = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (s_inst !== 4'hF) begin errors++; $display("FAIL wrap_full got=%h exp=f", s_inst); end
    tick();
    checks++;
    if (s_inst !== 4'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", s_inst); end
    checks++;
    if (InstRetCnt !== 32'd16) begin errors++; $display("FAIL wrap_wide got=%0d exp=16", InstRetCnt); end
    idle();
  endtask

  initial begin
    reset = 0; idle(); RA1 = 0; RA2 = 0; RA3 = 0; PCPlus8 = 0;
    test_reset();
    test_bypass();
    test_load();
    test_pc_write();
    test_counters();
    test_reset_write();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
